mode_ac_pulse_timestamper: RTL
==============================

Name: mode_ac_pulse_timestamper

Overview:
- Sits directly downstream of the Mode A/C edge detector and consumes its `rise_edge_out` / `fall_edge_out` strobes plus the shared sample-valid strobe.
- Timestamps each rising edge in sample ticks and measures pulse width to the matching falling edge.
- Pushes one pulse record per pulse into a small show-ahead FIFO; the Mode A/C framing and decoding logic reads that FIFO over a valid/ready stream.

Parameters:
- TS_WIDTH, 32: width of the free-running sample-tick timestamp counter.
- WIDTH_BITS, 16: width of the pulse-width field in each record.
- MAX_WIDTH, 4000: sample ticks after a rise with no fall before the pulse is closed as a timeout. Must be less than 2^WIDTH_BITS.
- DEPTH, 8: FIFO depth in records. Power of two, minimum 2.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- sample_valid  in  1  sample strobe, the same one that feeds the edge detector's `data_valid`.
- rise_edge_in  in  1  from edge detector `rise_edge_out`. A level that may stay high for several clocks.
- fall_edge_in  in  1  from edge detector `fall_edge_out`. Same level behaviour as rise_edge_in.
- clear  in  1  synchronous flush.
- pulse_valid  out  1  head record available.
- pulse_ready  in  1  consumer accepts the head record.
- pulse_start  out  TS_WIDTH  timestamp of the rise, head record.
- pulse_width  out  WIDTH_BITS  fall timestamp minus rise timestamp, head record.
- pulse_timeout  out  1  head record was closed by timeout.
- fifo_level  out  $clog2(DEPTH)+1  number of records held.
- drop_count  out  16  records lost because the FIFO was full; saturates.
- spurious_count  out  16  fall edges seen in IDLE, plus edges discarded by the coincidence rule; saturates.

Behaviour:
- Reset (asynchronous, active-high): all registers cleared.
  - ts counter = 0, state = IDLE, FIFO empty.
  - pulse_valid = 0, pulse_start = 0, pulse_width = 0, pulse_timeout = 0, fifo_level = 0, drop_count = 0, spurious_count = 0.
  - Edge-input history registers = 0.
- Edge qualification: the inputs are registered each clk. An event is a 0→1 transition, i.e. `in & ~in_d`. A multi-cycle-high input gives exactly one event.
- ts counter: increments by 1 on each clk with sample_valid = 1 and wraps modulo 2^TS_WIDTH. An event is stamped with the counter value present in its detection cycle.
- elapsed = (ts - start_reg) mod 2^TS_WIDTH, truncated to WIDTH_BITS. The subtraction must wrap correctly across counter rollover.
- State machine:
  - IDLE:
    - rise event: start_reg ← ts, go to WAIT_FALL.
    - fall event: spurious_count +1, stay in IDLE.
  - WAIT_FALL:
    - fall event: push {start_reg, elapsed, timeout=0}, go to IDLE.
    - Otherwise, if elapsed ≥ MAX_WIDTH: push {start_reg, MAX_WIDTH, timeout=1}, go to IDLE.
    - rise event without fall: restart, start_reg ← ts, spurious_count +1.
- Coincident rise and fall events in one cycle:
  - In WAIT_FALL: the fall wins and closes the pulse; the rise is discarded and spurious_count +1.
  - In IDLE: the rise is taken and the fall is discarded, spurious_count +1.
- Timeout and fall event in the same cycle: the fall wins and timeout = 0.
- FIFO:
  - Show-ahead: pulse_valid = ~empty. Head fields are valid whenever pulse_valid = 1 and stay stable until a pop.
  - Pop when pulse_valid & pulse_ready.
  - Push with FIFO full and no pop that cycle: record dropped, drop_count +1.
  - Push with FIFO full and a pop in the same cycle: push accepted, level unchanged.
  - Push with FIFO empty: pulse_valid rises the next clk; there is no fall-through.
- Latency: event detection is 1 clk after the input transition. The record is visible on pulse_* 2 clks after fall_edge_in rises.
- clear (synchronous, highest priority after rst):
  - Empties the FIFO and forces state = IDLE.
  - Zeroes drop_count and spurious_count.
  - Does NOT touch the ts counter or the edge history.
  - Any event in the clear cycle is ignored.
- Counters saturate at 16'hFFFF and never wrap.
- sample_valid affects the ts counter only. Edges are processed in every clk regardless of sample_valid.

Test Plan:
- **Basic pulse.** Reset; sample_valid every clk; rise when ts = 100, fall at ts = 130; pulse_ready = 1 → one record: start = 100, width = 30, timeout = 0, pulse_valid high for 1 clk.
- **Held-level inputs.** sample_valid every 4th clk; rise_edge_in held high 4 clks, fall_edge_in held high 4 clks → exactly one record; width equals the ts difference; spurious_count = 0.
- **Timeout.** MAX_WIDTH = 50; rise at ts = 10 and no fall → record start = 10, width = 50, timeout = 1. A later fall gives spurious_count = 1.
- **Full and concurrent.** DEPTH = 4, pulse_ready = 0, 6 pulses → fifo_level = 4, drop_count = 2, and the head is the first pulse. Then one push and one pop in the same clk at full → level stays 4 and the new record is retained.
- **Wrap and coincidence.** TS_WIDTH = 8; rise at ts = 250, fall at ts = 4 → width = 10. Separately, a coincident rise + fall in WAIT_FALL → pulse closed and spurious_count +1.
- **Mid-operation reset/clear.** Assert clear in WAIT_FALL with 3 records queued → fifo_level = 0, state IDLE, counters 0, ts keeps counting. Assert rst asynchronously mid-clock → all outputs 0 immediately.

Source files
------------

// File: rtl/mode_ac_pulse_timestamper.sv
// Mode A/C pulse timestamper.
// Qualifies rise/fall strobes from the edge detector, stamps each rise with
// the free-running sample-tick counter, measures the width to the matching
// fall (or closes the pulse on timeout) and queues one record per pulse in a
// small show-ahead FIFO read over a valid/ready stream.
module mode_ac_pulse_timestamper #(
   parameter int TS_WIDTH   = 32,
   parameter int WIDTH_BITS = 16,
   parameter int MAX_WIDTH  = 4000,
   parameter int DEPTH      = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     sample_valid,
   input  logic                     rise_edge_in,
   input  logic                     fall_edge_in,
   input  logic                     clear,
   output logic                     pulse_valid,
   input  logic                     pulse_ready,
   output logic [TS_WIDTH-1:0]      pulse_start,
   output logic [WIDTH_BITS-1:0]    pulse_width,
   output logic                     pulse_timeout,
   output logic [$clog2(DEPTH):0]   fifo_level,
   output logic [15:0]              drop_count,
   output logic [15:0]              spurious_count
);

   localparam int AW = $clog2(DEPTH);
   localparam int LW = $clog2(DEPTH) + 1;
   localparam logic [WIDTH_BITS-1:0] MAX_W    = WIDTH_BITS'(MAX_WIDTH);
   localparam logic [LW-1:0]         FULL_LVL = LW'(DEPTH);

   typedef enum logic {
      IDLE,
      WAIT_FALL
   } state_t;

   typedef struct packed {
      logic [TS_WIDTH-1:0]   start;
      logic [WIDTH_BITS-1:0] width;
      logic                  timeout;
   } rec_t;

   // ------------------------------------------------------------------
   // Edge qualification and timestamp counter
   // ------------------------------------------------------------------
   logic                rise_q, rise_d, fall_q, fall_d;
   logic                rise_ev, fall_ev;
   logic [TS_WIDTH-1:0] ts_q;

   // Two-deep history per strobe; the event is the registered 0->1 step, so a
   // level held for many clocks yields a single event. clear leaves it alone.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rise_q <= 1'b0;
         rise_d <= 1'b0;
         fall_q <= 1'b0;
         fall_d <= 1'b0;
      end else begin
         rise_q <= rise_edge_in;
         rise_d <= rise_q;
         fall_q <= fall_edge_in;
         fall_d <= fall_q;
      end
   end

   assign rise_ev = rise_q & ~rise_d;
   assign fall_ev = fall_q & ~fall_d;

   // Free-running sample-tick counter; wraps naturally, untouched by clear.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         ts_q <= '0;
      else if (sample_valid)
         ts_q <= ts_q + TS_WIDTH'(1);
   end

   // ------------------------------------------------------------------
   // Pulse tracking FSM
   // ------------------------------------------------------------------
   state_t                state_q, state_n;
   logic [TS_WIDTH-1:0]   start_q, start_n;
   logic [TS_WIDTH-1:0]   ts_diff;
   logic [WIDTH_BITS-1:0] elapsed;
   logic                  timeout_hit;
   logic                  rec_push;
   rec_t                  rec_n;
   logic                  spur_inc;

   // Modular subtraction in counter width keeps the width right across
   // counter rollover; the result is then sized to the record field.
   assign ts_diff     = ts_q - start_q;
   assign elapsed     = WIDTH_BITS'(ts_diff);
   assign timeout_hit = (elapsed >= MAX_W);

   // State register; clear parks the FSM in IDLE and drops that cycle's events.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         start_q <= '0;
      end else if (clear) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_n;
         start_q <= start_n;
      end
   end

   // Next state and record generation. A fall always beats a timeout or a
   // rise in the same cycle; a rise that cannot open or restart a pulse is
   // counted as spurious. At most one spurious increment per cycle.
   always_comb begin
      state_n  = state_q;
      start_n  = start_q;
      rec_push = 1'b0;
      rec_n    = '0;
      spur_inc = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (rise_ev) begin
               start_n  = ts_q;
               state_n  = WAIT_FALL;
               spur_inc = fall_ev;
            end else if (fall_ev) begin
               spur_inc = 1'b1;
            end
         end
         WAIT_FALL: begin
            if (fall_ev) begin
               rec_push      = 1'b1;
               rec_n.start   = start_q;
               rec_n.width   = elapsed;
               rec_n.timeout = 1'b0;
               state_n       = IDLE;
               spur_inc      = rise_ev;
            end else if (timeout_hit) begin
               rec_push      = 1'b1;
               rec_n.start   = start_q;
               rec_n.width   = MAX_W;
               rec_n.timeout = 1'b1;
               state_n       = IDLE;
               spur_inc      = rise_ev;
            end else if (rise_ev) begin
               start_n  = ts_q;
               spur_inc = 1'b1;
            end
         end
         default: state_n = IDLE;
      endcase
   end

   // ------------------------------------------------------------------
   // Show-ahead record FIFO
   // ------------------------------------------------------------------
   rec_t          mem [DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic [LW-1:0] level_q;
   logic          full, pop, do_push, drop_ev;
   rec_t          head;

   assign full    = (level_q == FULL_LVL);
   assign pop     = pulse_valid & pulse_ready;
   // A pop in the same cycle frees the slot, so a push at full still lands.
   assign do_push = rec_push & ~clear & (~full | pop);
   assign drop_ev = rec_push & ~clear & full & ~pop;

   // Record storage; when full with a concurrent pop, wr_ptr == rd_ptr and the
   // head being read out this cycle is replaced by the new tail record.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++)
            mem[i] <= '0;
      end else if (do_push) begin
         mem[wr_ptr] <= rec_n;
      end
   end

   // Pointers and occupancy; clear empties the queue outright.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         level_q <= '0;
      end else if (clear) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         level_q <= '0;
      end else begin
         if (do_push)
            wr_ptr <= wr_ptr + AW'(1);
         if (pop)
            rd_ptr <= rd_ptr + AW'(1);
         level_q <= level_q + LW'(do_push) - LW'(pop);
      end
   end

   // ------------------------------------------------------------------
   // Saturating diagnostic counters
   // ------------------------------------------------------------------
   logic [15:0] drop_q, spur_q;

   // Drop and spurious counters stick at all-ones rather than wrapping.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         drop_q <= '0;
         spur_q <= '0;
      end else if (clear) begin
         drop_q <= '0;
         spur_q <= '0;
      end else begin
         if (drop_ev && (drop_q != 16'hFFFF))
            drop_q <= drop_q + 16'd1;
         if (spur_inc && (spur_q != 16'hFFFF))
            spur_q <= spur_q + 16'd1;
      end
   end

   // ------------------------------------------------------------------
   // Outputs: head fields are forced to zero while the FIFO is empty so an
   // idle or freshly reset block presents an all-zero record.
   // ------------------------------------------------------------------
   assign head           = mem[rd_ptr];
   assign pulse_valid    = (level_q != '0);
   assign pulse_start    = pulse_valid ? head.start   : '0;
   assign pulse_width    = pulse_valid ? head.width   : '0;
   assign pulse_timeout  = pulse_valid ? head.timeout : 1'b0;
   assign fifo_level     = level_q;
   assign drop_count     = drop_q;
   assign spurious_count = spur_q;

endmodule
